// File: rtl/ExceptStruct.sv
// Exception pack handed over by the commit-stage exception examiner.
package ExceptStruct;

  localparam int unsigned EXLEN = 64;

  typedef struct packed {
    logic             except;
    logic [EXLEN-1:0] epc;
    logic [EXLEN-1:0] ecause;
    logic [EXLEN-1:0] etval;
  } ExceptPack;

endpackage

// File: rtl/TrapCtrlPkg.sv
// Shared definitions for the trap/return commit controller: FSM states, CSR addresses,
// mstatus field positions, privilege levels and xRET request encodings.
package TrapCtrlPkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TE_EPC,
    ST_TE_CAUSE,
    ST_TE_TVAL,
    ST_TE_STATUS,
    ST_RET_STATUS,
    ST_REDIRECT
  } trap_state_e;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;
  localparam logic [11:0] CSR_SEPC    = 12'h141;
  localparam logic [11:0] CSR_SCAUSE  = 12'h142;
  localparam logic [11:0] CSR_STVAL   = 12'h143;

  localparam int MSTATUS_SIE    = 1;
  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_SPIE   = 5;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_SPP    = 8;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  localparam logic [1:0] PRIV_U = 2'b00;
  localparam logic [1:0] PRIV_S = 2'b01;
  localparam logic [1:0] PRIV_M = 2'b11;

  localparam logic [1:0] RET_MRET = 2'b10;
  localparam logic [1:0] RET_SRET = 2'b01;

endpackage

// File: rtl/trap_target_calc.sv
// Combinational delegation decision and trap-vector target computation.
module trap_target_calc
  import TrapCtrlPkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic [1:0]      priv_i,
  input  logic [XLEN-1:0] ecause_i,
  input  logic [XLEN-1:0] medeleg_i,
  input  logic [XLEN-1:0] mideleg_i,
  input  logic [XLEN-1:0] mtvec_i,
  input  logic [XLEN-1:0] stvec_i,
  input  logic            useS_i,
  output logic            toS_o,
  output logic [XLEN-1:0] target_o
);

  logic            isIrq;
  logic [XLEN-1:0] delegMask;
  logic [XLEN-1:0] tvec;
  logic [XLEN-1:0] tvecBase;
  logic [XLEN-1:0] vecOffset;

  // Machine mode never delegates; vectored mode only applies to interrupts.
  always_comb begin
    isIrq     = ecause_i[XLEN-1];
    delegMask = isIrq ? mideleg_i : medeleg_i;
    toS_o     = (priv_i != PRIV_M) && delegMask[ecause_i[5:0]];
    tvec      = useS_i ? stvec_i : mtvec_i;
    tvecBase  = {tvec[XLEN-1:2], 2'b00};
    vecOffset = {1'b0, ecause_i[XLEN-2:0]} << 2;
    target_o  = ((tvec[1:0] == 2'b01) && isIrq) ? (tvecBase + vecOffset) : tvecBase;
  end

endmodule

// File: rtl/trap_commit_ctrl.sv
// Sequences trap entry and xRET: flush, one CSR write per state, privilege change,
// then a single-cycle PC redirect. Owns the current privilege level.
module trap_commit_ctrl
  import TrapCtrlPkg::*;
#(
  parameter int unsigned XLEN       = 64,
  parameter logic [1:0]  RESET_PRIV = 2'b11
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  ExceptStruct::ExceptPack except_commit,
  input  logic                    valid_wb,
  input  logic [1:0]              csr_ret_wb,
  input  logic [XLEN-1:0]         mstatus_i,
  input  logic [XLEN-1:0]         mtvec_i,
  input  logic [XLEN-1:0]         stvec_i,
  input  logic [XLEN-1:0]         mepc_i,
  input  logic [XLEN-1:0]         sepc_i,
  input  logic [XLEN-1:0]         medeleg_i,
  input  logic [XLEN-1:0]         mideleg_i,
  output logic [1:0]              priv_o,
  output logic                    stall_o,
  output logic                    flush_o,
  output logic                    csr_we_o,
  output logic [11:0]             csr_waddr_o,
  output logic [XLEN-1:0]         csr_wdata_o,
  output logic                    redirect_o,
  output logic [XLEN-1:0]         redirect_pc_o
);

  trap_state_e     state_q;
  logic [1:0]      priv_q;
  logic            toS_q;
  logic            isMret_q;
  logic [XLEN-1:0] epc_q;
  logic [XLEN-1:0] ecause_q;
  logic [XLEN-1:0] etval_q;
  logic [XLEN-1:0] redirPc_q;

  logic            retReq;
  logic            delegS;
  logic [XLEN-1:0] trapPc;
  logic [XLEN-1:0] calcCause;
  logic [1:0]      retPriv;
  logic [XLEN-1:0] mstatusTrap;
  logic [XLEN-1:0] mstatusRet;

  assign retReq    = valid_wb && ((csr_ret_wb == RET_MRET) || (csr_ret_wb == RET_SRET));
  assign calcCause = (state_q == ST_IDLE) ? except_commit.ecause : ecause_q;
  assign retPriv   = isMret_q ? mstatus_i[MSTATUS_MPP_HI:MSTATUS_MPP_LO]
                              : {1'b0, mstatus_i[MSTATUS_SPP]};

  trap_target_calc #(
    .XLEN(XLEN)
  ) u_target (
    .priv_i    (priv_q),
    .ecause_i  (calcCause),
    .medeleg_i (medeleg_i),
    .mideleg_i (mideleg_i),
    .mtvec_i   (mtvec_i),
    .stvec_i   (stvec_i),
    .useS_i    (toS_q),
    .toS_o     (delegS),
    .target_o  (trapPc)
  );

  // An exception takes priority over a simultaneous xRET; the pack is frozen on entry.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      priv_q    <= RESET_PRIV;
      toS_q     <= 1'b0;
      isMret_q  <= 1'b0;
      epc_q     <= '0;
      ecause_q  <= '0;
      etval_q   <= '0;
      redirPc_q <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (except_commit.except) begin
            state_q  <= ST_TE_EPC;
            toS_q    <= delegS;
            epc_q    <= except_commit.epc;
            ecause_q <= except_commit.ecause;
            etval_q  <= except_commit.etval;
          end else if (retReq) begin
            state_q  <= ST_RET_STATUS;
            isMret_q <= (csr_ret_wb == RET_MRET);
          end
        end
        ST_TE_EPC:   state_q <= ST_TE_CAUSE;
        ST_TE_CAUSE: state_q <= ST_TE_TVAL;
        ST_TE_TVAL:  state_q <= ST_TE_STATUS;
        ST_TE_STATUS: begin
          state_q   <= ST_REDIRECT;
          priv_q    <= toS_q ? PRIV_S : PRIV_M;
          redirPc_q <= trapPc;
        end
        ST_RET_STATUS: begin
          state_q   <= ST_REDIRECT;
          priv_q    <= retPriv;
          redirPc_q <= isMret_q ? mepc_i : sepc_i;
        end
        ST_REDIRECT: state_q <= ST_IDLE;
        default:     state_q <= ST_IDLE;
      endcase
    end
  end

  // mstatus images written on trap entry and on return, built from the live CSR value.
  always_comb begin
    mstatusTrap = mstatus_i;
    if (toS_q) begin
      mstatusTrap[MSTATUS_SPIE] = mstatus_i[MSTATUS_SIE];
      mstatusTrap[MSTATUS_SIE]  = 1'b0;
      mstatusTrap[MSTATUS_SPP]  = priv_q[0];
    end else begin
      mstatusTrap[MSTATUS_MPIE] = mstatus_i[MSTATUS_MIE];
      mstatusTrap[MSTATUS_MIE]  = 1'b0;
      mstatusTrap[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = priv_q;
    end

    mstatusRet = mstatus_i;
    if (isMret_q) begin
      mstatusRet[MSTATUS_MIE]  = mstatus_i[MSTATUS_MPIE];
      mstatusRet[MSTATUS_MPIE] = 1'b1;
      mstatusRet[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = PRIV_U;
    end else begin
      mstatusRet[MSTATUS_SIE]  = mstatus_i[MSTATUS_SPIE];
      mstatusRet[MSTATUS_SPIE] = 1'b1;
      mstatusRet[MSTATUS_SPP]  = 1'b0;
    end
  end

  always_comb begin
    csr_we_o    = 1'b0;
    csr_waddr_o = '0;
    csr_wdata_o = '0;
    unique case (state_q)
      ST_TE_EPC: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = toS_q ? CSR_SEPC : CSR_MEPC;
        csr_wdata_o = epc_q;
      end
      ST_TE_CAUSE: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = toS_q ? CSR_SCAUSE : CSR_MCAUSE;
        csr_wdata_o = ecause_q;
      end
      ST_TE_TVAL: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = toS_q ? CSR_STVAL : CSR_MTVAL;
        csr_wdata_o = etval_q;
      end
      ST_TE_STATUS: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = CSR_MSTATUS;
        csr_wdata_o = mstatusTrap;
      end
      ST_RET_STATUS: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = CSR_MSTATUS;
        csr_wdata_o = mstatusRet;
      end
      default: ;
    endcase
  end

  assign priv_o        = priv_q;
  assign stall_o       = (state_q != ST_IDLE);
  assign flush_o       = (state_q == ST_IDLE) && (except_commit.except || retReq);
  assign redirect_o    = (state_q == ST_REDIRECT);
  assign redirect_pc_o = redirPc_q;

endmodule

// File: tb/tb_trap_commit_ctrl.sv
// Scoreboard bench for trap_commit_ctrl: expected CSR writes and redirects are queued
// per scenario and matched in order against what the DUT emits.
module tb_trap_commit_ctrl;
  import TrapCtrlPkg::*;

  typedef struct packed {
    logic        redir;
    logic [11:0] addr;
    logic [63:0] data;
    logic [7:0]  cyc;
  } ev_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  ExceptStruct::ExceptPack pk = '0;
  logic        validWb = 1'b0;
  logic [1:0]  csrRet = 2'b00;
  logic [63:0] mstatus = '0, mtvec = '0, stvec = '0, mepc = '0, sepc = '0;
  logic [63:0] medeleg = '0, mideleg = '0;

  logic [1:0]  priv_o;
  logic        stall_o, flush_o, csr_we_o, redirect_o;
  logic [11:0] csr_waddr_o;
  logic [63:0] csr_wdata_o, redirect_pc_o;

  ev_t expQ[$];
  ev_t obsQ[$];
  int  checks = 0;
  int  failures = 0;
  int  stallCnt;
  logic flushAtLaunch, stallAtLaunch;

  trap_commit_ctrl #(.XLEN(64), .RESET_PRIV(2'b11)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .except_commit (pk),
    .valid_wb      (validWb),
    .csr_ret_wb    (csrRet),
    .mstatus_i     (mstatus),
    .mtvec_i       (mtvec),
    .stvec_i       (stvec),
    .mepc_i        (mepc),
    .sepc_i        (sepc),
    .medeleg_i     (medeleg),
    .mideleg_i     (mideleg),
    .priv_o        (priv_o),
    .stall_o       (stall_o),
    .flush_o       (flush_o),
    .csr_we_o      (csr_we_o),
    .csr_waddr_o   (csr_waddr_o),
    .csr_wdata_o   (csr_wdata_o),
    .redirect_o    (redirect_o),
    .redirect_pc_o (redirect_pc_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got timeout need finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic exp_csr(input logic [11:0] a, input logic [63:0] d, input int c);
    ev_t ev;
    ev = {1'b0, a, d, 8'(c)};
    expQ.push_back(ev);
  endtask

  task automatic exp_redir(input logic [63:0] pc, input int c);
    ev_t ev;
    ev = {1'b1, 12'h000, pc, 8'(c)};
    expQ.push_back(ev);
  endtask

  // Drives one request for a single cycle (called at posedge+1) and records DUT events.
  task automatic run_seq(input logic exc, input logic [63:0] epc, input logic [63:0] cause,
                         input logic [63:0] tval, input logic vwb, input logic [1:0] ret,
                         input int budget);
    ev_t ev;
    obsQ.delete();
    stallCnt = 0;
    pk.except = exc; pk.epc = epc; pk.ecause = cause; pk.etval = tval;
    validWb = vwb; csrRet = ret;
    #1;
    flushAtLaunch = flush_o;
    stallAtLaunch = stall_o;
    @(posedge clk); #1;
    pk = '0; validWb = 1'b0; csrRet = 2'b00;
    for (int c = 1; c <= budget; c++) begin
      if (csr_we_o) begin
        ev = {1'b0, csr_waddr_o, csr_wdata_o, 8'(c)};
        obsQ.push_back(ev);
      end
      if (redirect_o) begin
        ev = {1'b1, 12'h000, redirect_pc_o, 8'(c)};
        obsQ.push_back(ev);
      end
      if (stall_o) stallCnt++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (priv_o !== 2'b11) begin
      failures++; $display("[TB] FAIL reset_priv got %b need 11", priv_o);
    end
    checks++;
    if ({stall_o, flush_o, csr_we_o, csr_waddr_o, csr_wdata_o, redirect_o, redirect_pc_o} !== '0) begin
      failures++;
      $display("[TB] FAIL reset_outputs got stall=%b flush=%b we=%b addr=%h data=%h redir=%b pc=%h need all 0",
               stall_o, flush_o, csr_we_o, csr_waddr_o, csr_wdata_o, redirect_o, redirect_pc_o);
    end
    rstn = 1'b1;
  endtask

  task automatic test_mret();
    ev_t e, o;
    mstatus = 64'h80; mepc = 64'h8000_0100; sepc = 64'h8000_0900;
    exp_csr(CSR_MSTATUS, 64'h88, 1);
    exp_redir(64'h8000_0100, 2);
    run_seq(1'b0, '0, '0, '0, 1'b1, RET_MRET, 4);
    while (expQ.size() > 0) begin
      e = expQ.pop_front(); checks++;
      if (obsQ.size() == 0) begin failures++; $display("[TB] FAIL mret_sb got none need %h", e); end
      else begin
        o = obsQ.pop_front();
        if (o !== e) begin failures++; $display("[TB] FAIL mret_sb got %h need %h", o, e); end
      end
    end
    checks++;
    if (obsQ.size() != 0) begin failures++; $display("[TB] FAIL mret_extra got %0d need 0", obsQ.size()); end
    checks++;
    if (flushAtLaunch !== 1'b1) begin failures++; $display("[TB] FAIL mret_flush got %b need 1", flushAtLaunch); end
    checks++;
    if (stallCnt != 2) begin failures++; $display("[TB] FAIL mret_stall got %0d need 2", stallCnt); end
    checks++;
    if (priv_o !== PRIV_U) begin failures++; $display("[TB] FAIL mret_priv got %b need 00", priv_o); end
  endtask

  task automatic test_umode_illegal();
    ev_t e, o;
    mstatus = 64'h88; mtvec = 64'h8000_1000; stvec = 64'h8020_0000;
    medeleg = '0; mideleg = '0;
    exp_csr(CSR_MEPC, 64'h8000_0010, 1);
    exp_csr(CSR_MCAUSE, 64'd2, 2);
    exp_csr(CSR_MTVAL, 64'h0000_FFFF, 3);
    exp_csr(CSR_MSTATUS, 64'h80, 4);
    exp_redir(64'h8000_1000, 5);
    run_seq(1'b1, 64'h8000_0010, 64'd2, 64'h0000_FFFF, 1'b0, 2'b00, 7);
    while (expQ.size() > 0) begin
      e = expQ.pop_front(); checks++;
      if (obsQ.size() == 0) begin failures++; $display("[TB] FAIL umode_sb got none need %h", e); end
      else begin
        o = obsQ.pop_front();
        if (o !== e) begin failures++; $display("[TB] FAIL umode_sb got %h need %h", o, e); end
      end
    end
    checks++;
    if (obsQ.size() != 0) begin failures++; $display("[TB] FAIL umode_extra got %0d need 0", obsQ.size()); end
    checks++;
    if (flushAtLaunch !== 1'b1) begin failures++; $display("[TB] FAIL umode_flush got %b need 1", flushAtLaunch); end
    checks++;
    if (stallCnt != 5) begin failures++; $display("[TB] FAIL umode_stall got %0d need 5", stallCnt); end
    checks++;
    if (priv_o !== PRIV_M) begin failures++; $display("[TB] FAIL umode_priv got %b need 11", priv_o); end
  endtask

  task automatic test_smode_ecall();
    ev_t e, o;
    mstatus = 64'h800;
    run_seq(1'b0, '0, '0, '0, 1'b1, RET_MRET, 4);
    checks++;
    if (priv_o !== PRIV_S) begin failures++; $display("[TB] FAIL smode_setup_priv got %b need 01", priv_o); end
    mstatus = 64'h2; medeleg = 64'h200; mideleg = '0; stvec = 64'h8020_0000;
    exp_csr(CSR_SEPC, 64'h8020_0400, 1);
    exp_csr(CSR_SCAUSE, 64'd9, 2);
    exp_csr(CSR_STVAL, 64'd0, 3);
    exp_csr(CSR_MSTATUS, 64'h120, 4);
    exp_redir(64'h8020_0000, 5);
    run_seq(1'b1, 64'h8020_0400, 64'd9, 64'd0, 1'b0, 2'b00, 7);
    while (expQ.size() > 0) begin
      e = expQ.pop_front(); checks++;
      if (obsQ.size() == 0) begin failures++; $display("[TB] FAIL ecall_sb got none need %h", e); end
      else begin
        o = obsQ.pop_front();
        if (o !== e) begin failures++; $display("[TB] FAIL ecall_sb got %h need %h", o, e); end
      end
    end
    checks++;
    if (obsQ.size() != 0) begin failures++; $display("[TB] FAIL ecall_extra got %0d need 0", obsQ.size()); end
    checks++;
    if (priv_o !== PRIV_S) begin failures++; $display("[TB] FAIL ecall_priv got %b need 01", priv_o); end
  endtask

  task automatic test_collision();
    ev_t e, o;
    mstatus = 64'h8; medeleg = 64'h200; mtvec = 64'h8000_1000; mepc = 64'h8000_0100;
    exp_csr(CSR_MEPC, 64'h8020_0500, 1);
    exp_csr(CSR_MCAUSE, 64'd2, 2);
    exp_csr(CSR_MTVAL, 64'h1234, 3);
    exp_csr(CSR_MSTATUS, 64'h880, 4);
    exp_redir(64'h8000_1000, 5);
    run_seq(1'b1, 64'h8020_0500, 64'd2, 64'h1234, 1'b1, RET_MRET, 7);
    while (expQ.size() > 0) begin
      e = expQ.pop_front(); checks++;
      if (obsQ.size() == 0) begin failures++; $display("[TB] FAIL collide_sb got none need %h", e); end
      else begin
        o = obsQ.pop_front();
        if (o !== e) begin failures++; $display("[TB] FAIL collide_sb got %h need %h", o, e); end
      end
    end
    checks++;
    if (obsQ.size() != 0) begin failures++; $display("[TB] FAIL collide_extra got %0d need 0", obsQ.size()); end
    checks++;
    if (priv_o !== PRIV_M) begin failures++; $display("[TB] FAIL collide_priv got %b need 11", priv_o); end
  endtask

  task automatic test_vectored_irq();
    ev_t e, o;
    mstatus = 64'h8; mtvec = 64'h8000_0001; medeleg = '1; mideleg = '1;
    exp_csr(CSR_MEPC, 64'h8000_0200, 1);
    exp_csr(CSR_MCAUSE, 64'h8000_0000_0000_0007, 2);
    exp_csr(CSR_MTVAL, 64'd0, 3);
    exp_csr(CSR_MSTATUS, 64'h1880, 4);
    exp_redir(64'h8000_001C, 5);
    run_seq(1'b1, 64'h8000_0200, 64'h8000_0000_0000_0007, 64'd0, 1'b0, 2'b00, 7);
    while (expQ.size() > 0) begin
      e = expQ.pop_front(); checks++;
      if (obsQ.size() == 0) begin failures++; $display("[TB] FAIL vec_sb got none need %h", e); end
      else begin
        o = obsQ.pop_front();
        if (o !== e) begin failures++; $display("[TB] FAIL vec_sb got %h need %h", o, e); end
      end
    end
    checks++;
    if (obsQ.size() != 0) begin failures++; $display("[TB] FAIL vec_extra got %0d need 0", obsQ.size()); end
    checks++;
    if (priv_o !== PRIV_M) begin failures++; $display("[TB] FAIL vec_priv got %b need 11", priv_o); end
  endtask

  task automatic test_back_to_back();
    ev_t e, o;
    mstatus = 64'h8; mtvec = 64'h8000_1000; medeleg = '0; mideleg = '0;
    for (int k = 0; k < 2; k++) begin
      exp_csr(CSR_MEPC, 64'h8000_0300, 1);
      exp_csr(CSR_MCAUSE, 64'd5, 2);
      exp_csr(CSR_MTVAL, 64'h40, 3);
      exp_csr(CSR_MSTATUS, 64'h1880, 4);
      exp_redir(64'h8000_1000, 5);
      run_seq(1'b1, 64'h8000_0300, 64'd5, 64'h40, 1'b0, 2'b00, (k == 0) ? 5 : 7);
      while (expQ.size() > 0) begin
        e = expQ.pop_front(); checks++;
        if (obsQ.size() == 0) begin failures++; $display("[TB] FAIL b2b%0d_sb got none need %h", k, e); end
        else begin
          o = obsQ.pop_front();
          if (o !== e) begin failures++; $display("[TB] FAIL b2b%0d_sb got %h need %h", k, o, e); end
        end
      end
      checks++;
      if (obsQ.size() != 0) begin failures++; $display("[TB] FAIL b2b%0d_extra got %0d need 0", k, obsQ.size()); end
      checks++;
      if (stallCnt != 5) begin failures++; $display("[TB] FAIL b2b%0d_stall got %0d need 5", k, stallCnt); end
      checks++;
      if (stallAtLaunch !== 1'b0 || flushAtLaunch !== 1'b1) begin
        failures++;
        $display("[TB] FAIL b2b%0d_launch got stall=%b flush=%b need stall=0 flush=1", k, stallAtLaunch, flushAtLaunch);
      end
    end
  endtask

  task automatic test_reset_mid();
    int redirCnt;
    mstatus = 64'h80;
    run_seq(1'b0, '0, '0, '0, 1'b1, RET_MRET, 4);
    checks++;
    if (priv_o !== PRIV_U) begin failures++; $display("[TB] FAIL rmid_setup_priv got %b need 00", priv_o); end
    mtvec = 64'h8000_1000; medeleg = '0;
    pk.except = 1'b1; pk.epc = 64'h8000_0400; pk.ecause = 64'd2; pk.etval = 64'd0;
    @(posedge clk); #1;
    pk = '0;
    @(posedge clk); #1;
    checks++;
    if (csr_we_o !== 1'b1 || csr_waddr_o !== CSR_MCAUSE) begin
      failures++; $display("[TB] FAIL rmid_in_cause got we=%b addr=%h need we=1 addr=342", csr_we_o, csr_waddr_o);
    end
    rstn = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (priv_o !== PRIV_M || stall_o !== 1'b0 || csr_we_o !== 1'b0 || redirect_o !== 1'b0) begin
      failures++;
      $display("[TB] FAIL rmid_reset got priv=%b stall=%b we=%b redir=%b need priv=11 stall=0 we=0 redir=0",
               priv_o, stall_o, csr_we_o, redirect_o);
    end
    rstn = 1'b1;
    redirCnt = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (redirect_o || stall_o) redirCnt++;
    end
    checks++;
    if (redirCnt != 0) begin failures++; $display("[TB] FAIL rmid_quiet got %0d busy cycles need 0", redirCnt); end
  endtask

  initial begin
    test_reset();
    test_mret();
    test_umode_illegal();
    test_smode_ecall();
    test_collision();
    test_vectored_irq();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
